gsim_sweep_sched: RTL and testbench
===================================

// Module: gsim_sweep_sched
// PURPOSE
//  Sweep scheduler for the dual-PE Gauss-Seidel solver datapath. Issues the N/2
//  row-pair slots of each sweep to the PE pair: lane 0 gets issue_row, lane 1 gets
//  issue_row+N/2. Counts PE results and tracks the sweep's max |x_new-x_old|.
//  Stops on convergence (max delta <= tol after MIN_ITER sweeps) or at MAX_ITER,
//  then sequences the N-row read-out of x.
// PARAMETERS
//  N         16   unknowns per system; even; N/2 row-pair slots per sweep
//  MAX_ITER  84   hard sweep limit
//  MIN_ITER  4    sweeps completed before the convergence test may pass
//  DW        32   delta/tolerance width (same format as x, unsigned magnitude)
//  ITW       7    iteration counter width, >= clog2(MAX_ITER+1)
// PORTS
//  clk          in   1    clock
//  reset        in   1    asynchronous, active-high reset
//  start        in   1    begin solve; sampled only in IDLE
//  tol          in   DW   convergence threshold; latched on accepted start
//  busy         out  1    1 in every state except IDLE
//  issue_valid  out  1    row-pair slot offered to PE pair
//  issue_ready  in   1    PE pair accepts slot this cycle
//  issue_row    out  4    lane-0 row index, 0..N/2-1
//  iter_cnt     out  ITW  index of current sweep, 0-based
//  res_valid    in   1    one row-pair result returned
//  res_delta    in   DW   max of both lanes' |x_new-x_old| for that result
//  rd_valid     out  1    x read-out strobe
//  rd_row       out  4    row to read, 0..N-1
//  done         out  1    1-cycle pulse after last read-out row
//  converged    out  1    1 = stopped by tolerance, 0 = hit MAX_ITER; held to next start
//  iter_used    out  ITW  sweeps completed; held to next start
//  err          out  1    sticky protocol error; cleared by accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs, counters, max_delta and latched tol = 0.
//   Async reset mid-solve aborts immediately: no done, no rd_valid.
//  All outputs are registered or decoded from state/counter registers only.
//  IDLE: start=1 latches tol; clears iter, row, res_cnt, max_delta, err,
//   converged, iter_used; next state ISSUE. start outside IDLE is ignored.
//  ISSUE: issue_valid=1, issue_row=row. On valid&ready, row++.
//   Row N/2-1 accepted -> DRAIN. While ready=0, issue_row holds.
//  Result tracking in ISSUE/DRAIN: each res_valid increments res_cnt and sets
//   max_delta = max(max_delta, res_delta). Results may arrive with any latency,
//   including the cycle after acceptance.
//  DRAIN: issue_valid=0; when res_cnt reaches N/2 -> CHECK. A res_valid in the
//   same cycle counts toward N/2.
//  CHECK (1 cycle): let k = iter+1.
//   max_delta<=tol && k>=MIN_ITER -> converged=1, iter_used=k -> OUT.
//   Else k==MAX_ITER -> converged=0, iter_used=k -> OUT.
//   Else iter=k; row, res_cnt, max_delta cleared -> ISSUE.
//   max_delta==tol counts as converged.
//  OUT: rd_valid=1 for exactly N consecutive cycles, rd_row 0..N-1; no
//   backpressure. Cycle after rd_row=N-1: done=1 for 1 cycle, state IDLE.
//  err set on: res_valid in IDLE/CHECK/OUT; or res_valid with res_cnt==N/2.
//   The offending result is discarded (no count, no max update).
//  iter_cnt never wraps: max value MAX_ITER-1 during sweeps.
// TESTING
//  1 tol=32'hFFFF_FFFF, ready=1, res 1 cycle after issue -> 4 sweeps,
//    converged=1, iter_used=4, rd_row 0..15 on 16 cycles, done 1 cycle.
//  2 tol=0, all res_delta=1 -> 84 sweeps, converged=0, iter_used=84, 16 reads, done.
//  3 tol=10, per-sweep deltas {100,50,25,12,10}, one row 200 on sweep 0 ->
//    stops after sweep 5, iter_used=5, converged=1.
//  4 issue_ready alternating 0/1 with result latency 3 -> rows 0..7 each
//    accepted once per sweep, issue_row stable while stalled; results match test 1.
//  5 extra res_valid after 8th result of a sweep -> err=1, max unchanged;
//    err stays 1 until next start.
//  6 reset asserted mid-ISSUE of sweep 2 -> busy=0, all outputs 0 immediately;
//    fresh start then reproduces test 1 exactly.

Source files
------------

// File: rtl/gsim_sweep_sched.sv
// Sweep scheduler for the dual-PE Gauss-Seidel datapath: issues row-pair slots,
// collects per-sweep max delta, decides convergence and sequences x read-out.
module gsim_sweep_sched #(
  parameter int unsigned N        = 16,
  parameter int unsigned MAX_ITER = 84,
  parameter int unsigned MIN_ITER = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned ITW      = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [DW-1:0]  tol,
  output logic           busy,
  output logic           issue_valid,
  input  logic           issue_ready,
  output logic [3:0]     issue_row,
  output logic [ITW-1:0] iter_cnt,
  input  logic           res_valid,
  input  logic [DW-1:0]  res_delta,
  output logic           rd_valid,
  output logic [3:0]     rd_row,
  output logic           done,
  output logic           converged,
  output logic [ITW-1:0] iter_used,
  output logic           err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StOut   = 3'd4;

  localparam int unsigned Half    = N / 2;
  localparam int unsigned HalfM1  = N / 2 - 1;
  localparam int unsigned LastRow = N - 1;

  localparam logic [3:0]     SlotLast = HalfM1[3:0];
  localparam logic [3:0]     SlotCnt  = Half[3:0];
  localparam logic [3:0]     RowLast  = LastRow[3:0];
  localparam logic [ITW-1:0] IterMax  = MAX_ITER[ITW-1:0];
  localparam logic [ITW-1:0] IterMin  = MIN_ITER[ITW-1:0];

  logic [2:0]     state_q, state_d;
  logic [DW-1:0]  tol_q, tol_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     res_cnt_q, res_cnt_d;
  logic [DW-1:0]  max_q, max_d;
  logic           err_q, err_d;
  logic           conv_q, conv_d;
  logic [ITW-1:0] used_q, used_d;
  logic [3:0]     rd_row_q, rd_row_d;
  logic           done_q, done_d;

  logic           res_ok;
  logic           res_bad;
  logic [ITW-1:0] k;

  assign k = iter_q + 1'b1;

  // A result is only usable while a sweep is open and still owes results.
  always_comb begin
    res_ok  = 1'b0;
    res_bad = 1'b0;
    if (res_valid) begin
      if ((state_q == StIssue || state_q == StDrain) && res_cnt_q != SlotCnt) begin
        res_ok = 1'b1;
      end else begin
        res_bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tol_d     = tol_q;
    iter_d    = iter_q;
    row_d     = row_q;
    res_cnt_d = res_cnt_q;
    max_d     = max_q;
    err_d     = err_q;
    conv_d    = conv_q;
    used_d    = used_q;
    rd_row_d  = rd_row_q;
    done_d    = 1'b0;

    if (res_ok) begin
      res_cnt_d = res_cnt_q + 4'd1;
      if (res_delta > max_q) max_d = res_delta;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          tol_d     = tol;
          iter_d    = '0;
          row_d     = '0;
          res_cnt_d = '0;
          max_d     = '0;
          err_d     = 1'b0;
          conv_d    = 1'b0;
          used_d    = '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (issue_ready) begin
          // Hold the last slot index in DRAIN so issue_row stays in range.
          if (row_q == SlotLast) state_d = StDrain;
          else                   row_d   = row_q + 4'd1;
        end
      end
      StDrain: begin
        if (res_cnt_d == SlotCnt) state_d = StCheck;
      end
      StCheck: begin
        if (max_q <= tol_q && k >= IterMin) begin
          conv_d   = 1'b1;
          used_d   = k;
          rd_row_d = '0;
          state_d  = StOut;
        end else if (k == IterMax) begin
          conv_d   = 1'b0;
          used_d   = k;
          rd_row_d = '0;
          state_d  = StOut;
        end else begin
          iter_d    = k;
          row_d     = '0;
          res_cnt_d = '0;
          max_d     = '0;
          state_d   = StIssue;
        end
      end
      StOut: begin
        if (rd_row_q == RowLast) begin
          rd_row_d = '0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          rd_row_d = rd_row_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (res_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tol_q     <= '0;
      iter_q    <= '0;
      row_q     <= '0;
      res_cnt_q <= '0;
      max_q     <= '0;
      err_q     <= 1'b0;
      conv_q    <= 1'b0;
      used_q    <= '0;
      rd_row_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tol_q     <= tol_d;
      iter_q    <= iter_d;
      row_q     <= row_d;
      res_cnt_q <= res_cnt_d;
      max_q     <= max_d;
      err_q     <= err_d;
      conv_q    <= conv_d;
      used_q    <= used_d;
      rd_row_q  <= rd_row_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign issue_valid = (state_q == StIssue);
  assign issue_row   = row_q;
  assign iter_cnt    = iter_q;
  assign rd_valid    = (state_q == StOut);
  assign rd_row      = rd_row_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign iter_used   = used_q;
  assign err         = err_q;

endmodule

// File: tb/tb_gsim_sweep_sched.sv
// Directed bench for gsim_sweep_sched with a behavioural PE-pair responder
// (configurable result latency, ready pattern and per-row delta values).
module tb_gsim_sweep_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] tol;
  logic        busy;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [3:0]  issue_row;
  logic [6:0]  iter_cnt;
  logic        res_valid = 1'b0;
  logic [31:0] res_delta = 32'd0;
  logic        rd_valid;
  logic [3:0]  rd_row;
  logic        done;
  logic        converged;
  logic [6:0]  iter_used;
  logic        err;

  gsim_sweep_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tol        (tol),
    .busy       (busy),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_row  (issue_row),
    .iter_cnt   (iter_cnt),
    .res_valid  (res_valid),
    .res_delta  (res_delta),
    .rd_valid   (rd_valid),
    .rd_row     (rd_row),
    .done       (done),
    .converged  (converged),
    .iter_used  (iter_used),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Responder configuration and observations.
  int          mode       = 0;
  int          lat        = 1;
  int          ready_mode = 0;
  bit          inject_en  = 1'b0;
  bit          inject_pending = 1'b0;
  bit          pv [8];
  logic [31:0] pd [8];
  int          acc_cnt [8];
  int          stall_viol;
  int          max_iter_seen;
  int          res_seen;
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_row   = 4'd0;

  // Results of the last run_solve.
  int r_reads;
  bit r_rows_ok;
  int r_done_cnt;
  bit r_done_after_last;
  bit r_timeout;
  bit r_busy_gap;

  function automatic logic [31:0] pe_delta(input int m, input int it, input int r);
    if (m == 0) return 32'(r * 3);
    if (m == 1) return 32'd1;
    if (m == 2) begin
      if (it == 0 && r == 3) return 32'd200;
      if (it == 0) return 32'd100;
      if (it == 1) return 32'd50;
      if (it == 2) return 32'd25;
      if (it == 3) return 32'd12;
      return 32'd10;
    end
    return 32'd5;
  endfunction

  // PE pair: accepts on valid&ready, returns one result lat cycles later.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
      res_valid      = 1'b0;
      inject_pending = 1'b0;
      prev_stall     = 1'b0;
    end else begin
      res_valid = pv[0];
      res_delta = pd[0];
      for (int i = 0; i < 7; i++) begin
        pv[i] = pv[i+1];
        pd[i] = pd[i+1];
      end
      pv[7] = 1'b0;
      if (inject_pending) begin
        res_valid      = 1'b1;
        res_delta      = 32'hFFFF_FFFF;
        inject_pending = 1'b0;
      end else if (res_valid) begin
        res_seen++;
        if (inject_en && res_seen == 8) inject_pending = 1'b1;
      end
      if (ready_mode == 0) issue_ready = 1'b1;
      else                 issue_ready = ~issue_ready;
      if (prev_stall && issue_valid && issue_row !== prev_row) stall_viol++;
      prev_stall = issue_valid && !issue_ready;
      prev_row   = issue_row;
      if (issue_valid && issue_ready) begin
        if (issue_row > 4'd7) stall_viol++;
        else acc_cnt[issue_row[2:0]]++;
        pv[lat-1] = 1'b1;
        pd[lat-1] = pe_delta(mode, int'(iter_cnt), int'(issue_row));
      end
      if (busy && int'(iter_cnt) > max_iter_seen) max_iter_seen = int'(iter_cnt);
    end
  end

  task automatic run_solve(input logic [31:0] t);
    bit last_was_end;
    r_reads = 0; r_rows_ok = 1'b1; r_done_cnt = 0; r_done_after_last = 1'b0;
    r_timeout = 1'b1; r_busy_gap = 1'b0; last_was_end = 1'b0;
    for (int i = 0; i < 8; i++) acc_cnt[i] = 0;
    stall_viol = 0; max_iter_seen = 0; res_seen = 0;
    @(negedge clk);
    tol   = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (rd_valid) begin
        if (rd_row !== 4'(r_reads)) r_rows_ok = 1'b0;
        r_reads++;
      end
      if (done === 1'b1) begin
        r_done_cnt++;
        r_done_after_last = last_was_end;
      end else if (r_done_cnt > 0) begin
        r_timeout = 1'b0;
        break;
      end else if (!busy) begin
        r_busy_gap = 1'b1;
      end
      last_was_end = rd_valid && rd_row == 4'd15;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tol = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, issue_valid, issue_row, iter_cnt, rd_valid, rd_row, done, converged, iter_used, err}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, issue_valid, issue_row, iter_cnt, rd_valid, rd_row, done, converged,
                iter_used, err});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_converge_fast();
    mode = 0; lat = 1; ready_mode = 0;
    run_solve(32'hFFFF_FFFF);
    n_cmp++;
    if (r_timeout) begin n_fail++; $display("FAIL t1_timeout: got timeout required done"); end
    n_cmp++;
    if (converged !== 1'b1) begin
      n_fail++; $display("FAIL t1_converged: got %b required 1", converged);
    end
    n_cmp++;
    if (iter_used !== 7'd4) begin
      n_fail++; $display("FAIL t1_iter_used: got %0d required 4", iter_used);
    end
    n_cmp++;
    if (r_reads != 16 || !r_rows_ok) begin
      n_fail++; $display("FAIL t1_readout: got %0d reads (order ok %0d) required 16 in order",
                         r_reads, r_rows_ok);
    end
    n_cmp++;
    if (r_done_cnt != 1 || !r_done_after_last) begin
      n_fail++; $display("FAIL t1_done: got %0d cycles (after last %0d) required 1 after row 15",
                         r_done_cnt, r_done_after_last);
    end
    n_cmp++;
    if (r_busy_gap || busy !== 1'b0) begin
      n_fail++; $display("FAIL t1_busy: got gap %0d final %b required no gap and 0",
                         r_busy_gap, busy);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b required 0", err); end
  endtask

  task automatic test_max_iter();
    mode = 1; lat = 1; ready_mode = 0;
    run_solve(32'd0);
    n_cmp++;
    if (r_timeout) begin n_fail++; $display("FAIL t2_timeout: got timeout required done"); end
    n_cmp++;
    if (converged !== 1'b0 || iter_used !== 7'd84) begin
      n_fail++; $display("FAIL t2_stop: got conv %b used %0d required conv 0 used 84",
                         converged, iter_used);
    end
    n_cmp++;
    if (max_iter_seen != 83) begin
      n_fail++; $display("FAIL t2_iter_cnt_max: got %0d required 83", max_iter_seen);
    end
    n_cmp++;
    if (r_reads != 16 || !r_rows_ok || r_done_cnt != 1) begin
      n_fail++; $display("FAIL t2_readout: got %0d reads done %0d required 16 reads done 1",
                         r_reads, r_done_cnt);
    end
  endtask

  task automatic test_tol_boundary();
    mode = 2; lat = 1; ready_mode = 0;
    run_solve(32'd10);
    n_cmp++;
    if (r_timeout) begin n_fail++; $display("FAIL t3_timeout: got timeout required done"); end
    n_cmp++;
    if (converged !== 1'b1 || iter_used !== 7'd5) begin
      n_fail++; $display("FAIL t3_stop: got conv %b used %0d required conv 1 used 5",
                         converged, iter_used);
    end
    n_cmp++;
    if (max_iter_seen != 4) begin
      n_fail++; $display("FAIL t3_last_sweep: got %0d required 4", max_iter_seen);
    end
  endtask

  task automatic test_backpressure();
    mode = 0; lat = 3; ready_mode = 1;
    run_solve(32'hFFFF_FFFF);
    n_cmp++;
    if (r_timeout) begin n_fail++; $display("FAIL t4_timeout: got timeout required done"); end
    n_cmp++;
    if (converged !== 1'b1 || iter_used !== 7'd4 || r_reads != 16 || r_done_cnt != 1) begin
      n_fail++; $display("FAIL t4_result: got conv %b used %0d reads %0d done %0d required 1/4/16/1",
                         converged, iter_used, r_reads, r_done_cnt);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (acc_cnt[r] != 4) begin
        n_fail++; $display("FAIL t4_accept_row%0d: got %0d required 4", r, acc_cnt[r]);
      end
    end
    n_cmp++;
    if (stall_viol != 0) begin
      n_fail++; $display("FAIL t4_row_stable: got %0d violations required 0", stall_viol);
    end
    ready_mode = 0; lat = 1;
  endtask

  task automatic test_protocol_err();
    mode = 3; lat = 1; ready_mode = 0; inject_en = 1'b1;
    run_solve(32'd100);
    inject_en = 1'b0;
    n_cmp++;
    if (converged !== 1'b1 || iter_used !== 7'd4 || r_timeout) begin
      n_fail++; $display("FAIL t5_solve: got conv %b used %0d timeout %0d required 1/4/0",
                         converged, iter_used, r_timeout);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL t5_err_sticky: got %b required 1", err); end
    run_solve(32'd100);
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL t5_err_clear: got %b required 0", err); end
    @(posedge clk);
    inject_pending = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_err_idle: got err %b busy %b required 1 0", err, busy);
    end
  endtask

  task automatic test_reset_midsolve();
    bit reached;
    bit leak;
    mode = 0; lat = 1; ready_mode = 0; reached = 1'b0; leak = 1'b0;
    @(negedge clk);
    tol = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if (issue_valid && iter_cnt == 7'd2 && issue_row == 4'd3) begin
        reached = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!reached) begin n_fail++; $display("FAIL t6_reach: got no sweep-2 issue required one"); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, issue_valid, issue_row, iter_cnt, rd_valid, rd_row, done, converged, iter_used, err}
        !== '0) begin
      n_fail++;
      $display("FAIL t6_async_clear: got %b required all zero",
               {busy, issue_valid, issue_row, iter_cnt, rd_valid, rd_row, done, converged,
                iter_used, err});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || rd_valid || done) leak = 1'b1;
    end
    n_cmp++;
    if (leak) begin n_fail++; $display("FAIL t6_no_leak: got activity after reset required none"); end
    test_converge_fast();
  endtask

  initial begin
    test_reset();
    test_converge_fast();
    test_max_iter();
    test_tol_boundary();
    test_backpressure();
    test_protocol_err();
    test_reset_midsolve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
